mem_rd_resp_router: RTL and testbench

Return-path companion to the layer memory-access multiplexer. The multiplexer forwards the active layer's read enables to the shared feature-map RAM and the two weight ROMs. This block sits on the data outputs of those memories. It tags every issued read with the layer code active at issue time and tracks it through the fixed memory read latency. When the data returns, it delivers it with a one-hot valid strobe to the issuing layer, even if the layer has already changed. It also reports in-flight status so the layer sequencer switches layers only when drained.

---
 rtl/mem_rd_resp_router_pkg.sv | 36 +++
 rtl/mem_rd_resp_router_if.sv | 44 ++++
 rtl/mem_rd_resp_router_rd_tag_pipe.sv | 74 +++++++
 rtl/mem_rd_resp_router.sv | 75 +++++++
 tb/tb_mem_rd_resp_router.sv | 162 ++++++++++++++++
 5 files changed

// File: rtl/mem_rd_resp_router_pkg.sv
// Layer code constants and helpers shared by the read-response router and its bench.
// Latency: n/a (package only).
// Backpressure: n/a.
package mem_rd_resp_router_pkg;

    localparam int NUM_LAYERS = 8;

    localparam logic [3:0] IDLE  = 4'd0;
    localparam logic [3:0] CONV1 = 4'd1;
    localparam logic [3:0] MP1   = 4'd2;
    localparam logic [3:0] CONV2 = 4'd3;
    localparam logic [3:0] CONV3 = 4'd4;
    localparam logic [3:0] MP2   = 4'd5;
    localparam logic [3:0] FC1   = 4'd6;
    localparam logic [3:0] FC2   = 4'd7;
    localparam logic [3:0] FC3   = 4'd8;
    localparam logic [3:0] TB    = 4'd15;

    // Layer code to one-hot: bit k-1 for layer k (1..8), top bit for the tb code.
    function automatic logic [NUM_LAYERS:0] code_to_onehot(input logic [3:0] code);
        logic [NUM_LAYERS:0] oh;
        oh = '0;
        if (code == TB) begin
            oh[NUM_LAYERS] = 1'b1;
        end else if (code >= CONV1 && code <= FC3) begin
            oh[code - 4'd1] = 1'b1;
        end
        return oh;
    endfunction

    // Inverse mapping: the layer code that owns one-hot bit k.
    function automatic logic [3:0] bit_code(input int k);
        return (k == NUM_LAYERS) ? TB : 4'(k + 1);
    endfunction

endpackage

// File: rtl/mem_rd_resp_router_if.sv
// Bundle of memory-side enables/data and layer-side return strobes for the router.
// Latency: n/a (wiring only).
// Backpressure: none; the memories and layers never stall the return path.
interface mem_rd_resp_router_if
    import mem_rd_resp_router_pkg::*;
#(
    parameter int RAM_DW  = 8,
    parameter int ROMW_DW = 8,
    parameter int ROMO_DW = 16
);
    logic [3:0]              layer_id;
    logic                    ram_en_r;
    logic [RAM_DW-1:0]       ram_rdata;
    logic                    rom_en_rw;
    logic [ROMW_DW-1:0]      rom_rw_rdata;
    logic                    rom_en_row;
    logic [ROMO_DW-1:0]      rom_row_rdata;
    logic                    err_clr;

    logic [RAM_DW-1:0]       ram_rd_data;
    logic [NUM_LAYERS:0]     ram_rd_vld;
    logic [ROMW_DW-1:0]      rom_rw_data;
    logic [NUM_LAYERS-1:0]   rom_rw_vld;
    logic [ROMO_DW-1:0]      rom_row_data;
    logic [NUM_LAYERS-1:0]   rom_row_vld;
    logic [3:0]              inflight;
    logic                    drained;
    logic                    err_tag;

    modport master (
        output layer_id, ram_en_r, ram_rdata, rom_en_rw, rom_rw_rdata,
               rom_en_row, rom_row_rdata, err_clr,
        input  ram_rd_data, ram_rd_vld, rom_rw_data, rom_rw_vld,
               rom_row_data, rom_row_vld, inflight, drained, err_tag
    );

    modport slave (
        input  layer_id, ram_en_r, ram_rdata, rom_en_rw, rom_rw_rdata,
               rom_en_row, rom_row_rdata, err_clr,
        output ram_rd_data, ram_rd_vld, rom_rw_data, rom_rw_vld,
               rom_row_data, rom_row_vld, inflight, drained, err_tag
    );

endinterface

// File: rtl/mem_rd_resp_router_rd_tag_pipe.sv
// One channel: tags each read with its issue-time layer code and strobes that layer on return.
// Latency: RD_LAT+1 cycles from sampled enable to registered data/vld.
// Backpressure: none; accepts one read per cycle, returns one per cycle.
module mem_rd_resp_router_rd_tag_pipe
    import mem_rd_resp_router_pkg::*;
#(
    parameter int RD_LAT = 2,
    parameter int DW     = 8,
    parameter bit TB_OK  = 1'b1,
    parameter int VW     = TB_OK ? NUM_LAYERS + 1 : NUM_LAYERS
)(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en,
    input  logic [3:0]    code,
    input  logic [DW-1:0] rdata,
    output logic [DW-1:0] rd_data,
    output logic [VW-1:0] rd_vld,
    output logic          issue,
    output logic          retire,
    output logic          illegal
);

    localparam logic [NUM_LAYERS:0] LEGAL_MASK = TB_OK ? 9'h1FF : 9'h0FF;

    logic              legal;
    logic              vld_p  [RD_LAT];
    logic [3:0]        code_p [RD_LAT];
    logic [VW-1:0]     vld_d;

    assign legal   = |(code_to_onehot(code) & LEGAL_MASK);
    assign issue   = en & legal;
    assign illegal = en & ~legal;
    assign retire  = vld_p[RD_LAT-1];

    // Tag pipe: stage 0 captures the issue, later stages follow the memory latency.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < RD_LAT; i++) begin
                vld_p[i]  <= 1'b0;
                code_p[i] <= IDLE;
            end
        end else begin
            vld_p[0]  <= issue;
            code_p[0] <= code;
            for (int i = 1; i < RD_LAT; i++) begin
                vld_p[i]  <= vld_p[i-1];
                code_p[i] <= code_p[i-1];
            end
        end
    end

    // Decode the last-stage tag into the owning layer's strobe bit.
    always_comb begin
        vld_d = '0;
        for (int k = 0; k < VW; k++) begin
            vld_d[k] = vld_p[RD_LAT-1] && (code_p[RD_LAT-1] == bit_code(k));
        end
    end

    // Output stage: one-cycle strobe, data held between returns.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_vld  <= '0;
            rd_data <= '0;
        end else begin
            rd_vld <= vld_d;
            if (vld_p[RD_LAT-1]) begin
                rd_data <= rdata;
            end
        end
    end

endmodule

// File: rtl/mem_rd_resp_router.sv
// Routes RAM/ROM read returns to the issuing layer and reports outstanding reads.
// Latency: RD_LAT+1 cycles per read; channels independent, one read per cycle each.
// Backpressure: none; drained tells the sequencer when a layer switch is safe.
module mem_rd_resp_router
    import mem_rd_resp_router_pkg::*;
#(
    parameter int RD_LAT  = 2,
    parameter int RAM_DW  = 8,
    parameter int ROMW_DW = 8,
    parameter int ROMO_DW = 16
)(
    input  logic                 clk,
    input  logic                 rst_n,
    mem_rd_resp_router_if.slave  bus
);

    logic       ram_issue, ram_retire, ram_illegal;
    logic       rw_issue,  rw_retire,  rw_illegal;
    logic       row_issue, row_retire, row_illegal;
    logic [3:0] inc, dec;
    logic [3:0] inflight_q;
    logic       err_q;

    mem_rd_resp_router_rd_tag_pipe #(.RD_LAT(RD_LAT), .DW(RAM_DW), .TB_OK(1'b1)) u_ram (
        .clk(clk), .rst_n(rst_n),
        .en(bus.ram_en_r), .code(bus.layer_id), .rdata(bus.ram_rdata),
        .rd_data(bus.ram_rd_data), .rd_vld(bus.ram_rd_vld),
        .issue(ram_issue), .retire(ram_retire), .illegal(ram_illegal)
    );

    mem_rd_resp_router_rd_tag_pipe #(.RD_LAT(RD_LAT), .DW(ROMW_DW), .TB_OK(1'b0)) u_rom_rw (
        .clk(clk), .rst_n(rst_n),
        .en(bus.rom_en_rw), .code(bus.layer_id), .rdata(bus.rom_rw_rdata),
        .rd_data(bus.rom_rw_data), .rd_vld(bus.rom_rw_vld),
        .issue(rw_issue), .retire(rw_retire), .illegal(rw_illegal)
    );

    mem_rd_resp_router_rd_tag_pipe #(.RD_LAT(RD_LAT), .DW(ROMO_DW), .TB_OK(1'b0)) u_rom_row (
        .clk(clk), .rst_n(rst_n),
        .en(bus.rom_en_row), .code(bus.layer_id), .rdata(bus.rom_row_rdata),
        .rd_data(bus.rom_row_data), .rd_vld(bus.rom_row_vld),
        .issue(row_issue), .retire(row_retire), .illegal(row_illegal)
    );

    // Per-cycle issue and retire counts across the three channels.
    always_comb begin
        inc = {3'b000, ram_issue}  + {3'b000, rw_issue}  + {3'b000, row_issue};
        dec = {3'b000, ram_retire} + {3'b000, rw_retire} + {3'b000, row_retire};
    end

    // Outstanding-read counter; issue and retire in the same cycle cancel.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inflight_q <= 4'd0;
        end else begin
            inflight_q <= inflight_q + inc - dec;
        end
    end

    // Sticky illegal-code flag; a new error wins over a same-cycle clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else if (ram_illegal | rw_illegal | row_illegal) begin
            err_q <= 1'b1;
        end else if (bus.err_clr) begin
            err_q <= 1'b0;
        end
    end

    assign bus.inflight = inflight_q;
    assign bus.err_tag  = err_q;
    assign bus.drained  = (inflight_q == 4'd0) & ~bus.ram_en_r & ~bus.rom_en_rw & ~bus.rom_en_row;

endmodule

// File: tb/tb_mem_rd_resp_router.sv
// Self-checking bench: directed scenarios followed by random traffic, compared against a
// cycle-indexed reference model built from the issue history.
// Runs a fixed number of cycles, then prints one summary line.
module tb_mem_rd_resp_router;

    localparam int RD_LAT  = 2;
    localparam int RAM_DW  = 8;
    localparam int ROMW_DW = 8;
    localparam int ROMO_DW = 16;
    localparam int N       = 420;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    mem_rd_resp_router_if #(.RAM_DW(RAM_DW), .ROMW_DW(ROMW_DW), .ROMO_DW(ROMO_DW)) bus ();

    mem_rd_resp_router #(.RD_LAT(RD_LAT), .RAM_DW(RAM_DW), .ROMW_DW(ROMW_DW), .ROMO_DW(ROMO_DW)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    // Stimulus per cycle; channel 0 = RAM, 1 = weight ROM, 2 = other-weight ROM.
    logic        rl  [N];
    logic        en  [3][N];
    logic [15:0] dat [3][N];
    logic [3:0]  lid [N];
    logic        clr [N];

    int n_chk  = 0;
    int n_fail = 0;
    int cur    = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s cycle=%0d got=%h expected=%h", tag, cur, got, exp);
        end
    endtask

    function automatic bit legal(input int ch, input logic [3:0] code);
        return (code >= 4'd1 && code <= 4'd8) || (ch == 0 && code == 4'd15);
    endfunction

    // A read issued in cycle c is still live in cycle n if it was accepted and no reset hit since.
    function automatic bit alive(input int ch, input int c, input int n);
        if (c < 0) return 1'b0;
        if (!en[ch][c] || !legal(ch, lid[c])) return 1'b0;
        for (int k = c; k <= n; k++) begin
            if (rl[k]) return 1'b0;
        end
        return 1'b1;
    endfunction

    function automatic logic [31:0] onehot(input logic [3:0] code);
        if (code == 4'd15) return 32'h100;
        return 32'd1 << (code - 4'd1);
    endfunction

    initial begin
        logic [15:0] exp_d [3];
        logic [31:0] exp_v [3];
        logic        exp_err;
        int          infl;
        bit          rst_now, ill;
        int          c;

        bus.layer_id = '0; bus.ram_en_r = 1'b0; bus.ram_rdata = '0;
        bus.rom_en_rw = 1'b0; bus.rom_rw_rdata = '0;
        bus.rom_en_row = 1'b0; bus.rom_row_rdata = '0; bus.err_clr = 1'b0;

        // Background: idle or random traffic with occasional resets.
        for (int n = 0; n < N; n++) begin
            rl[n]  = (n < 4);
            clr[n] = 1'b0;
            lid[n] = 4'd0;
            for (int ch = 0; ch < 3; ch++) begin
                en[ch][n]  = 1'b0;
                dat[ch][n] = 16'($urandom) & ((ch == 2) ? 16'hFFFF : 16'h00FF);
            end
            if (n >= 70 && n < N - 10) begin
                lid[n] = ($urandom_range(0, 3) != 0) ? 4'($urandom_range(1, 8)) : 4'($urandom_range(0, 15));
                for (int ch = 0; ch < 3; ch++) en[ch][n] = ($urandom_range(0, 1) == 1);
                clr[n] = ($urandom_range(0, 19) == 0);
                rl[n]  = ($urandom_range(0, 149) == 0);
            end
        end

        // Directed scenarios.
        en[0][10] = 1'b1; lid[10] = 4'd1; dat[0][12] = 16'h005A;
        for (int n = 20; n <= 27; n++) begin en[1][n] = 1'b1; lid[n] = 4'd6; end
        en[0][30] = 1'b1; lid[30] = 4'd3; lid[31] = 4'd4;
        en[0][40] = 1'b1; lid[40] = 4'd2;
        en[0][50] = 1'b1; lid[50] = 4'd15;
        en[2][52] = 1'b1; lid[52] = 4'd15;
        clr[56] = 1'b1;
        en[0][60] = 1'b1; en[1][60] = 1'b1; en[2][60] = 1'b1; lid[60] = 4'd5;
        rl[61] = 1'b1;

        for (int ch = 0; ch < 3; ch++) exp_d[ch] = '0;
        exp_err = 1'b0;

        for (int n = 0; n < N; n++) begin
            @(posedge clk);
            #1;
            cur               = n;
            rst_n             = !rl[n];
            bus.layer_id      = lid[n];
            bus.ram_en_r      = en[0][n];
            bus.ram_rdata     = dat[0][n][7:0];
            bus.rom_en_rw     = en[1][n];
            bus.rom_rw_rdata  = dat[1][n][7:0];
            bus.rom_en_row    = en[2][n];
            bus.rom_row_rdata = dat[2][n];
            bus.err_clr       = clr[n];
            @(negedge clk);

            rst_now = (n == 0) ? 1'b1 : (rl[n] || rl[n-1]);
            c = n - RD_LAT - 1;
            infl = 0;
            for (int ch = 0; ch < 3; ch++) begin
                exp_v[ch] = '0;
                if (alive(ch, c, n)) begin
                    exp_v[ch] = onehot(lid[c]);
                    exp_d[ch] = dat[ch][n-1];
                end
                if (rst_now) exp_d[ch] = '0;
                for (int k = n - RD_LAT; k <= n - 1; k++) begin
                    if (alive(ch, k, n)) infl++;
                end
            end
            if (rst_now) begin
                exp_err = 1'b0;
            end else begin
                ill = 1'b0;
                for (int ch = 0; ch < 3; ch++) begin
                    if (en[ch][n-1] && !legal(ch, lid[n-1])) ill = 1'b1;
                end
                if (ill) exp_err = 1'b1;
                else if (clr[n-1]) exp_err = 1'b0;
            end

            chk("ram_rd_vld",   32'(bus.ram_rd_vld),   exp_v[0]);
            chk("ram_rd_data",  32'(bus.ram_rd_data),  32'(exp_d[0]));
            chk("rom_rw_vld",   32'(bus.rom_rw_vld),   exp_v[1]);
            chk("rom_rw_data",  32'(bus.rom_rw_data),  32'(exp_d[1]));
            chk("rom_row_vld",  32'(bus.rom_row_vld),  exp_v[2]);
            chk("rom_row_data", 32'(bus.rom_row_data), 32'(exp_d[2]));
            chk("inflight",     32'(bus.inflight),     32'(infl));
            chk("drained",      32'(bus.drained),
                32'((infl == 0) && !en[0][n] && !en[1][n] && !en[2][n]));
            chk("err_tag",      32'(bus.err_tag),      32'(exp_err));
        end

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule
